// File: rtl/hpm_counter_bank_if.sv
// CSR-side access bus of the performance monitor bank: index, register select,
// strobes and data, with a combinational read/error return.
interface hpm_counter_bank_if #(
    parameter int unsigned XLEN = 64
);
    logic [4:0]      idx_i;
    logic [1:0]      sel_i;
    logic            we_i;
    logic            re_i;
    logic [XLEN-1:0] wdata_i;
    logic [XLEN-1:0] rdata_o;
    logic            err_o;

    modport master (
        output idx_i, sel_i, we_i, re_i, wdata_i,
        input  rdata_o, err_o
    );

    modport slave (
        input  idx_i, sel_i, we_i, re_i, wdata_i,
        output rdata_o, err_o
    );
endinterface

// File: rtl/hpm_counter_bank.sv
// Hardware performance monitor bank: per-counter event lane select, multi-bit
// increments, sticky overflow flags and a level overflow interrupt.
module hpm_counter_bank #(
    parameter int unsigned NumCounters = 29,
    parameter int unsigned CntWidth    = 64,
    parameter int unsigned NumEvents   = 64,
    parameter int unsigned IncWidth    = 2,
    parameter int unsigned XLEN        = 64
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          debug_mode_i,
    hpm_counter_bank_if.slave             bus,
    input  logic [NumEvents*IncWidth-1:0] event_i,
    input  logic [NumCounters-1:0]        inhibit_i,
    output logic [NumCounters-1:0]        ovf_o,
    output logic                          irq_o
);
    localparam int unsigned ExtW = 128;

    typedef enum logic [1:0] {
        SelCntLo = 2'd0,
        SelCntHi = 2'd1,
        SelEvent = 2'd2,
        SelRsvd  = 2'd3
    } reg_sel_e;

    logic [CntWidth-1:0]    cnt_q   [NumCounters];
    logic [CntWidth-1:0]    cnt_d   [NumCounters];
    logic [7:0]             evsel_q [NumCounters];
    logic [7:0]             evsel_d [NumCounters];
    logic [NumCounters-1:0] minh_q, minh_d;
    logic [NumCounters-1:0] of_q, of_d;
    logic                   irq_q;

    reg_sel_e               sel;
    logic                   access;
    logic                   acc_err;
    logic                   wr_valid;
    logic [XLEN-1:0]        rdata;
    logic [ExtW-1:0]        rd_ext;
    logic [ExtW-1:0]        wr_ext;
    int unsigned            lane;
    logic [IncWidth-1:0]    inc;
    logic [CntWidth:0]      sum;

    assign sel      = reg_sel_e'(bus.sel_i);
    assign access   = bus.we_i | bus.re_i;
    assign wr_valid = bus.we_i & ~acc_err;

    always_comb begin
        acc_err = 1'b0;
        if (32'(bus.idx_i) >= NumCounters) acc_err = 1'b1;
        if (sel == SelRsvd)                acc_err = 1'b1;
        if (sel == SelCntHi && XLEN == 64) acc_err = 1'b1;
    end

    assign bus.err_o = access & acc_err;

    // Reads always show the registered state, never the write in flight.
    always_comb begin
        rdata  = '0;
        rd_ext = '0;
        if (access && !acc_err) begin
            for (int k = 0; k < NumCounters; k++) begin
                if (bus.idx_i == 5'(k)) begin
                    rd_ext = ExtW'(cnt_q[k]);
                    case (sel)
                        SelCntLo: rdata = rd_ext[XLEN-1:0];
                        SelCntHi: rdata = rd_ext[2*XLEN-1:XLEN];
                        SelEvent: begin
                            rdata[7:0]      = evsel_q[k];
                            rdata[XLEN-2]   = minh_q[k];
                            rdata[XLEN-1]   = of_q[k];
                        end
                        default:  rdata = '0;
                    endcase
                end
            end
        end
    end

    assign bus.rdata_o = rdata;

    // A counter write replaces that counter's increment; an EVENT write lets it
    // keep counting but the software OF value overrides any overflow.
    always_comb begin
        lane   = 0;
        inc    = '0;
        sum    = '0;
        wr_ext = '0;
        minh_d = minh_q;
        of_d   = of_q;
        for (int k = 0; k < NumCounters; k++) begin
            evsel_d[k] = evsel_q[k];
            lane = (32'(evsel_q[k]) < NumEvents) ? 32'(evsel_q[k]) : 0;
            inc  = '0;
            if (lane != 0 && !inhibit_i[k] && !(debug_mode_i && minh_q[k])) begin
                inc = event_i[lane*IncWidth +: IncWidth];
            end
            sum        = {1'b0, cnt_q[k]} + (CntWidth+1)'(inc);
            cnt_d[k]   = sum[CntWidth-1:0];
            of_d[k]    = of_q[k] | sum[CntWidth];
            if (wr_valid && bus.idx_i == 5'(k)) begin
                wr_ext = ExtW'(cnt_q[k]);
                case (sel)
                    SelCntLo: begin
                        wr_ext[XLEN-1:0] = bus.wdata_i;
                        cnt_d[k]         = wr_ext[CntWidth-1:0];
                        of_d[k]          = of_q[k];
                    end
                    SelCntHi: begin
                        wr_ext[2*XLEN-1:XLEN] = bus.wdata_i;
                        cnt_d[k]              = wr_ext[CntWidth-1:0];
                        of_d[k]               = of_q[k];
                    end
                    SelEvent: begin
                        evsel_d[k] = bus.wdata_i[7:0];
                        minh_d[k]  = bus.wdata_i[XLEN-2];
                        of_d[k]    = bus.wdata_i[XLEN-1];
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < NumCounters; k++) begin
                cnt_q[k]   <= '0;
                evsel_q[k] <= '0;
            end
            minh_q <= '0;
            of_q   <= '0;
            irq_q  <= 1'b0;
        end else begin
            for (int k = 0; k < NumCounters; k++) begin
                cnt_q[k]   <= cnt_d[k];
                evsel_q[k] <= evsel_d[k];
            end
            minh_q <= minh_d;
            of_q   <= of_d;
            irq_q  <= |of_q;
        end
    end

    assign ovf_o = of_q;
    assign irq_o = irq_q;
endmodule

// File: tb/tb_hpm_counter_bank.sv
// Self-checking bench for hpm_counter_bank: decode table, directed corner
// sequences, and randomized traffic against an arithmetic reference model.
module tb_hpm_counter_bank;
    logic         clk;
    logic         rst_ni;
    logic         debug_mode;
    logic [127:0] ev64;
    logic [28:0]  inh64;
    logic [28:0]  ovf64;
    logic         irq64;
    logic [15:0]  ev32;
    logic [3:0]   inh32;
    logic [3:0]   ovf32;
    logic         irq32;

    int checks = 0;
    int errors = 0;

    longint unsigned m_cnt  [29];
    bit [7:0]        m_sel  [29];
    bit              m_minh [29];
    bit              m_of   [29];
    bit              m_irq;

    hpm_counter_bank_if #(.XLEN(64)) bus64 ();
    hpm_counter_bank_if #(.XLEN(32)) bus32 ();

    hpm_counter_bank dut64 (
        .clk_i(clk), .rst_ni(rst_ni), .debug_mode_i(debug_mode), .bus(bus64),
        .event_i(ev64), .inhibit_i(inh64), .ovf_o(ovf64), .irq_o(irq64)
    );

    hpm_counter_bank #(
        .NumCounters(4), .CntWidth(64), .NumEvents(8), .IncWidth(2), .XLEN(32)
    ) dut32 (
        .clk_i(clk), .rst_ni(rst_ni), .debug_mode_i(debug_mode), .bus(bus32),
        .event_i(ev32), .inhibit_i(inh32), .ovf_o(ovf32), .irq_o(irq32)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [4:0]  idx;
        logic [1:0]  sel;
        logic        we;
        logic        re;
        logic [63:0] wdata;
        logic        exp_err;
    } vec_t;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [4:0] idx, input logic [1:0] sel,
                                 input logic we, input logic re, input logic [63:0] wdata);
        bus64.idx_i   = idx;
        bus64.sel_i   = sel;
        bus64.we_i    = we;
        bus64.re_i    = re;
        bus64.wdata_i = wdata;
    endtask

    task automatic idleBus32();
        bus32.idx_i   = 5'd0;
        bus32.sel_i   = 2'd0;
        bus32.we_i    = 1'b0;
        bus32.re_i    = 1'b0;
        bus32.wdata_i = 32'd0;
    endtask

    task automatic modelReset();
        for (int k = 0; k < 29; k++) begin
            m_cnt[k]  = 0;
            m_sel[k]  = 0;
            m_minh[k] = 0;
            m_of[k]   = 0;
        end
        m_irq = 0;
    endtask

    task automatic doReset();
        rst_ni     = 1'b0;
        debug_mode = 1'b0;
        ev64 = '0; inh64 = '0; ev32 = '0; inh32 = '0;
        applyStimulus(5'd0, 2'd0, 1'b0, 1'b0, 64'd0);
        idleBus32();
        modelReset();
        repeat (2) @(negedge clk);
        rst_ni = 1'b1;
    endtask

    task automatic write64(input int idx, input int sel, input logic [63:0] data);
        @(negedge clk);
        applyStimulus(5'(idx), 2'(sel), 1'b1, 1'b0, data);
        @(negedge clk);
        applyStimulus(5'd0, 2'd0, 1'b0, 1'b0, 64'd0);
    endtask

    task automatic read64(input string name, input int idx, input int sel, input logic [63:0] exp);
        applyStimulus(5'(idx), 2'(sel), 1'b0, 1'b1, 64'd0);
        #1;
        checkOutput(name, bus64.rdata_o, exp);
        applyStimulus(5'd0, 2'd0, 1'b0, 1'b0, 64'd0);
    endtask

    task automatic write32(input int idx, input int sel, input logic [31:0] data);
        @(negedge clk);
        bus32.idx_i = 5'(idx); bus32.sel_i = 2'(sel); bus32.we_i = 1'b1; bus32.wdata_i = data;
        @(negedge clk);
        idleBus32();
    endtask

    task automatic read32(input string name, input int idx, input int sel, input logic [31:0] exp);
        bus32.idx_i = 5'(idx); bus32.sel_i = 2'(sel); bus32.re_i = 1'b1;
        #1;
        checkOutput(name, 64'(bus32.rdata_o), 64'(exp));
        checkOutput({name, "_err"}, 64'(bus32.err_o), 64'd0);
        idleBus32();
    endtask

    // Reference model: one clock edge of the bank, in plain 64-bit arithmetic.
    task automatic modelStep(input logic [127:0] ev, input logic [28:0] inh, input logic dbg,
                             input logic [4:0] idx, input logic [1:0] sel, input logic wr,
                             input logic [63:0] wd);
        bit any_of = 0;
        for (int k = 0; k < 29; k++) any_of |= m_of[k];
        for (int k = 0; k < 29; k++) begin
            int lane;
            longint unsigned inc, nxt;
            lane = (m_sel[k] < 64) ? int'(m_sel[k]) : 0;
            inc  = (lane == 0 || inh[k] || (dbg && m_minh[k])) ? 0 : 64'(ev[lane*2 +: 2]);
            if (wr && idx == 5'(k) && sel == 2'd0) begin
                m_cnt[k] = wd;
            end else begin
                nxt = m_cnt[k] + inc;
                if (nxt < m_cnt[k]) m_of[k] = 1;
                m_cnt[k] = nxt;
            end
            if (wr && idx == 5'(k) && sel == 2'd2) begin
                m_sel[k]  = wd[7:0];
                m_minh[k] = wd[62];
                m_of[k]   = wd[63];
            end
        end
        m_irq = any_of;
    endtask

    task automatic randomPhase(input int cycles);
        logic [127:0] ev;
        logic [28:0]  inh, exp_ovf;
        logic         dbg, we, re, exp_err;
        logic [4:0]   idx;
        logic [1:0]   sel;
        logic [63:0]  wd, exp_rd;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            ev  = {$urandom, $urandom, $urandom, $urandom};
            for (int k = 0; k < 29; k++) inh[k] = ($urandom_range(0, 7) == 0);
            dbg = ($urandom_range(0, 3) == 0);
            idx = 5'($urandom_range(0, 31));
            sel = 2'($urandom_range(0, 3));
            we  = 1'($urandom_range(0, 1));
            re  = 1'($urandom_range(0, 1));
            wd  = {$urandom, $urandom};
            if (sel == 2'd0 && $urandom_range(0, 1) == 1)
                wd = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
            if (sel == 2'd2) wd[63] = ($urandom_range(0, 3) == 0);
            ev64 = ev; inh64 = inh; debug_mode = dbg;
            applyStimulus(idx, sel, we, re, wd);
            #1;
            exp_err = (we || re) && (idx >= 5'd29 || sel == 2'd3 || sel == 2'd1);
            exp_rd  = 64'd0;
            if ((we || re) && !exp_err) begin
                if (sel == 2'd0) exp_rd = m_cnt[idx];
                else             exp_rd = {m_of[idx], m_minh[idx], 54'd0, m_sel[idx]};
            end
            for (int k = 0; k < 29; k++) exp_ovf[k] = m_of[k];
            checkOutput("rnd_err",   64'(bus64.err_o), 64'(exp_err));
            checkOutput("rnd_rdata", bus64.rdata_o, exp_rd);
            checkOutput("rnd_ovf",   64'(ovf64), 64'(exp_ovf));
            checkOutput("rnd_irq",   64'(irq64), 64'(m_irq));
            @(posedge clk);
            modelStep(ev, inh, dbg, idx, sel, we && !exp_err, wd);
        end
        @(negedge clk);
        ev64 = '0; inh64 = '0; debug_mode = 1'b0;
        applyStimulus(5'd0, 2'd0, 1'b0, 1'b0, 64'd0);
    endtask

    vec_t vecs[11];

    initial begin
        vecs[0]  = '{5'd0,  2'd0, 1'b0, 1'b1, 64'd0, 1'b0};
        vecs[1]  = '{5'd28, 2'd0, 1'b0, 1'b1, 64'd0, 1'b0};
        vecs[2]  = '{5'd28, 2'd2, 1'b0, 1'b1, 64'd0, 1'b0};
        vecs[3]  = '{5'd0,  2'd1, 1'b0, 1'b1, 64'd0, 1'b1};
        vecs[4]  = '{5'd0,  2'd3, 1'b0, 1'b1, 64'd0, 1'b1};
        vecs[5]  = '{5'd29, 2'd0, 1'b0, 1'b1, 64'd0, 1'b1};
        vecs[6]  = '{5'd31, 2'd2, 1'b0, 1'b1, 64'd0, 1'b1};
        vecs[7]  = '{5'd5,  2'd3, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1};
        vecs[8]  = '{5'd5,  2'd1, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1};
        vecs[9]  = '{5'd29, 2'd2, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1};
        vecs[10] = '{5'd31, 2'd3, 1'b0, 1'b0, 64'd0, 1'b0};

        doReset();
        #1;
        checkOutput("rst_ovf", 64'(ovf64), 64'd0);
        checkOutput("rst_irq", 64'(irq64), 64'd0);
        checkOutput("rst_err_idle", 64'(bus64.err_o), 64'd0);
        checkOutput("rst_rdata_idle", bus64.rdata_o, 64'd0);
        for (int i = 0; i < 29; i++) begin
            read64($sformatf("rst_lo_%0d", i), i, 0, 64'd0);
            read64($sformatf("rst_ev_%0d", i), i, 2, 64'd0);
        end
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            applyStimulus(vecs[i].idx, vecs[i].sel, vecs[i].we, vecs[i].re, vecs[i].wdata);
            #1;
            checkOutput($sformatf("tbl_err_%0d", i), 64'(bus64.err_o), 64'(vecs[i].exp_err));
            checkOutput($sformatf("tbl_rdata_%0d", i), bus64.rdata_o, 64'd0);
        end
        @(negedge clk);
        applyStimulus(5'd0, 2'd0, 1'b0, 1'b0, 64'd0);
        read64("bad_wr_lo", 5, 0, 64'd0);
        read64("bad_wr_ev", 5, 2, 64'd0);

        // Lane select, lane 0 as "no event", out-of-range select
        doReset();
        write64(0, 2, 64'd5);
        write64(4, 2, 64'd200);
        ev64[11:10] = 2'd3;
        repeat (4) @(negedge clk);
        ev64 = '0;
        read64("t2_cnt12", 0, 0, 64'd12);
        ev64[1:0] = 2'd3;
        repeat (3) @(negedge clk);
        ev64 = '0;
        read64("t2_lane0", 1, 0, 64'd0);
        read64("t2_sel200_cnt", 4, 0, 64'd0);
        read64("t2_sel200_ev", 4, 2, 64'd200);
        read64("t2_hold12", 0, 0, 64'd12);

        // Wrap with overflow, interrupt timing, software clear, async reset
        doReset();
        write64(0, 2, 64'd7);
        write64(0, 0, 64'hFFFF_FFFF_FFFF_FFFE);
        ev64[15:14] = 2'd3;
        @(posedge clk);
        #1;
        read64("t3_wrap", 0, 0, 64'd1);
        checkOutput("t3_of_same_edge", 64'(ovf64[0]), 64'd1);
        checkOutput("t3_irq_not_yet", 64'(irq64), 64'd0);
        @(negedge clk);
        ev64 = '0;
        @(posedge clk);
        #1;
        checkOutput("t3_irq_next", 64'(irq64), 64'd1);
        @(negedge clk);
        read64("t3_ev_of", 0, 2, 64'h8000_0000_0000_0007);
        write64(0, 2, 64'd7);
        @(posedge clk);
        #1;
        checkOutput("t3_irq_clr", 64'(irq64), 64'd0);
        checkOutput("t3_of_clr", 64'(ovf64), 64'd0);
        write64(0, 2, 64'h8000_0000_0000_0007);
        @(posedge clk);
        #1;
        checkOutput("t3_sw_of_irq", 64'(irq64), 64'd1);
        #2;
        rst_ni = 1'b0;
        #1;
        checkOutput("t3_async_irq", 64'(irq64), 64'd0);
        checkOutput("t3_async_ovf", 64'(ovf64), 64'd0);
        @(negedge clk);
        rst_ni = 1'b1;

        // Write to one counter does not stall its neighbour
        doReset();
        write64(2, 2, 64'd1);
        write64(3, 2, 64'd1);
        ev64[3:2] = 2'd1;
        applyStimulus(5'd2, 2'd0, 1'b1, 1'b0, 64'd100);
        @(negedge clk);
        applyStimulus(5'd0, 2'd0, 1'b0, 1'b0, 64'd0);
        ev64 = '0;
        read64("t4_written", 2, 0, 64'd100);
        read64("t4_neighbour", 3, 0, 64'd1);

        // Debug-mode inhibit and mcountinhibit
        doReset();
        write64(0, 2, 64'h4000_0000_0000_0002);
        write64(1, 2, 64'd2);
        debug_mode = 1'b1;
        ev64[5:4] = 2'd1;
        repeat (3) @(negedge clk);
        read64("t5_minh_frozen", 0, 0, 64'd0);
        read64("t5_counts", 1, 0, 64'd3);
        inh64[1] = 1'b1;
        repeat (2) @(negedge clk);
        read64("t5_inhibit", 1, 0, 64'd3);
        inh64 = '0;
        debug_mode = 1'b0;
        @(negedge clk);
        ev64 = '0;
        read64("t5_minh_nodebug", 0, 0, 64'd1);
        read64("t5_ev_minh", 0, 2, 64'h4000_0000_0000_0002);

        // 32-bit CSR view of a 64-bit counter
        doReset();
        write32(0, 2, 32'd1);
        write32(0, 1, 32'hFFFF_FFFF);
        write32(0, 0, 32'hFFFF_FFFF);
        read32("t6_lo_pre", 0, 0, 32'hFFFF_FFFF);
        read32("t6_hi_pre", 0, 1, 32'hFFFF_FFFF);
        ev32[3:2] = 2'd1;
        @(negedge clk);
        ev32 = '0;
        read32("t6_lo", 0, 0, 32'd0);
        read32("t6_hi", 0, 1, 32'd0);
        read32("t6_ev", 0, 2, 32'h8000_0001);
        checkOutput("t6_ovf", 64'(ovf32), 64'd1);

        doReset();
        randomPhase(3000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
